// File: rtl/pio_input_edgecap.sv
// Avalon-MM input PIO: synchronised, optionally debounced inputs with sticky
// per-bit edge capture (write-1-to-clear) and a maskable level interrupt.
module pio_input_edgecap #(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 0,
    parameter int unsigned EDGE_TYPE       = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic             irq,
    input  logic [WIDTH-1:0] in_port
);

    localparam int unsigned DATA_W = 32;

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
    logic [WIDTH-1:0]  sync_out_c;
    logic [WIDTH-1:0]  data_reg_q, data_reg_d;
    logic [WIDTH-1:0]  data_prev_q, data_prev_d;
    logic [WIDTH-1:0]  edge_q, edge_d;
    logic [WIDTH-1:0]  mask_q, mask_d;
    logic [DATA_W-1:0] readdata_q, readdata_d;
    logic [WIDTH-1:0]  event_c;
    logic [WIDTH-1:0]  clear_c;
    logic              wr_en_c;
    logic              unused_wdata_c;

    // Synchroniser shift chain; stage 0 samples the raw pins
    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = in_port;
        for (int i = 1; i < int'(SYNC_STAGES); i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    assign sync_out_c = sync_q[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_no_debounce
            always_comb begin
                data_reg_d = sync_out_c;
            end
        end else begin : g_debounce
            localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

            logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;

            // A bit toggles only after differing for DEBOUNCE_CYCLES consecutive cycles
            always_comb begin
                cnt_d      = cnt_q;
                data_reg_d = data_reg_q;
                for (int i = 0; i < int'(WIDTH); i++) begin
                    if (sync_out_c[i] == data_reg_q[i]) begin
                        cnt_d[i] = '0;
                    end else if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                        data_reg_d[i] = ~data_reg_q[i];
                        cnt_d[i]      = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end
        end
    endgenerate

    // Edge event selection
    always_comb begin
        event_c = '0;
        case (EDGE_TYPE)
            0:       event_c = data_reg_q & ~data_prev_q;
            1:       event_c = ~data_reg_q & data_prev_q;
            default: event_c = data_reg_q ^ data_prev_q;
        endcase
    end

    assign wr_en_c        = chipselect & ~write_n;
    assign unused_wdata_c = ^writedata;

    // Register updates; a new event beats a same-cycle clear
    always_comb begin
        data_prev_d = data_reg_q;
        clear_c     = '0;
        mask_d      = mask_q;
        if (wr_en_c && address == 2'd3) begin
            clear_c = writedata[WIDTH-1:0];
        end
        if (wr_en_c && address == 2'd2) begin
            mask_d = writedata[WIDTH-1:0];
        end
        edge_d = (edge_q & ~clear_c) | event_c;
    end

    // Read mux sampled every cycle regardless of chipselect
    always_comb begin
        readdata_d = '0;
        case (address)
            2'd0:    readdata_d = DATA_W'(data_reg_q);
            2'd2:    readdata_d = DATA_W'(mask_q);
            2'd3:    readdata_d = DATA_W'(edge_q);
            default: readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q      <= '0;
            data_reg_q  <= '0;
            data_prev_q <= '0;
            edge_q      <= '0;
            mask_q      <= '0;
            readdata_q  <= '0;
        end else begin
            sync_q      <= sync_d;
            data_reg_q  <= data_reg_d;
            data_prev_q <= data_prev_d;
            edge_q      <= edge_d;
            mask_q      <= mask_d;
            readdata_q  <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(edge_q & mask_q);

endmodule

// File: tb/tb_pio_input_edgecap.sv
// Bench for pio_input_edgecap: four differently configured instances on a shared
// bus, compared every cycle against a delay-line/window reference model.
module tb_pio_input_edgecap;

    localparam int unsigned NI = 4;
    localparam int unsigned PW [NI] = '{4, 4, 32, 8};
    localparam int unsigned PS [NI] = '{2, 2, 3, 2};
    localparam int unsigned PD [NI] = '{0, 4, 0, 2};
    localparam int unsigned PE [NI] = '{0, 0, 1, 2};

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [31:0] in_v [NI];
    logic [31:0] rd_a [NI];
    logic [NI-1:0] irq_v;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pio_input_edgecap #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(0)) u0 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd_a[0]), .irq(irq_v[0]),
        .in_port(in_v[0][3:0]));
    pio_input_edgecap #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0)) u1 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd_a[1]), .irq(irq_v[1]),
        .in_port(in_v[1][3:0]));
    pio_input_edgecap #(.WIDTH(32), .SYNC_STAGES(3), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(1)) u2 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd_a[2]), .irq(irq_v[2]),
        .in_port(in_v[2][31:0]));
    pio_input_edgecap #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(2), .EDGE_TYPE(2)) u3 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd_a[3]), .irq(irq_v[3]),
        .in_port(in_v[3][7:0]));

    function automatic logic [31:0] wmask(int unsigned w);
        return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: input delay line, D-sample agreement window, sticky capture
    logic [31:0] m_sh   [NI][4];
    logic [31:0] m_hist [NI][4];
    logic [31:0] m_dreg [NI];
    logic [31:0] m_prev [NI];
    logic [31:0] m_cap  [NI];
    logic [31:0] m_mask [NI];
    logic [31:0] m_rd   [NI];

    always @(posedge clk or negedge reset_n) begin
        logic [31:0] wm, so, evt, clr, acc, nd, nrd;
        logic        wr;
        if (!reset_n) begin
            for (int k = 0; k < NI; k++) begin
                for (int j = 0; j < 4; j++) begin
                    m_sh[k][j]   = 32'd0;
                    m_hist[k][j] = 32'd0;
                end
                m_dreg[k] = 32'd0; m_prev[k] = 32'd0; m_cap[k] = 32'd0;
                m_mask[k] = 32'd0; m_rd[k] = 32'd0;
            end
        end else begin
            wr = chipselect && !write_n;
            for (int k = 0; k < NI; k++) begin
                wm = wmask(PW[k]);
                so = m_sh[k][PS[k]-1];
                case (address)
                    2'd0:    nrd = m_dreg[k];
                    2'd2:    nrd = m_mask[k];
                    2'd3:    nrd = m_cap[k];
                    default: nrd = 32'd0;
                endcase
                case (PE[k])
                    0:       evt = m_dreg[k] & ~m_prev[k];
                    1:       evt = ~m_dreg[k] & m_prev[k];
                    default: evt = m_dreg[k] ^ m_prev[k];
                endcase
                evt = evt & wm;
                clr = (wr && address == 2'd3) ? (writedata & wm) : 32'd0;
                if (PD[k] == 0) begin
                    nd = so;
                end else begin
                    for (int j = 3; j > 0; j--) m_hist[k][j] = m_hist[k][j-1];
                    m_hist[k][0] = so;
                    acc = wm;
                    for (int j = 0; j < int'(PD[k]); j++) acc = acc & (m_hist[k][j] ^ m_dreg[k]);
                    nd = m_dreg[k] ^ acc;
                end
                if (wr && address == 2'd2) m_mask[k] = writedata & wm;
                m_cap[k]  = (m_cap[k] & ~clr) | evt;
                m_prev[k] = m_dreg[k];
                m_dreg[k] = nd;
                m_rd[k]   = nrd;
                for (int j = 3; j > 0; j--) m_sh[k][j] = m_sh[k][j-1];
                m_sh[k][0] = in_v[k] & wm;
            end
        end
    end

    // Continuous comparison against the model
    always @(negedge clk) begin
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("rd%0d", k), rd_a[k], m_rd[k]);
            chk($sformatf("irq%0d", k), 32'(irq_v[k]), 32'(|(m_cap[k] & m_mask[k])));
        end
    end

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic bus_write(logic [1:0] a, logic [31:0] d);
        address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
        tick(1);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic set_addr(logic [1:0] a);
        address = a;
        tick(1);
    endtask

    initial begin
        for (int k = 0; k < NI; k++) in_v[k] = 32'd0;
        tick(3);
        chk("reset_rd0", rd_a[0], 32'd0);
        chk("reset_irq0", 32'(irq_v[0]), 32'd0);
        reset_n = 1'b1;

        // Basic capture of 0101
        in_v[0] = 32'h5;
        tick(6);
        set_addr(2'd0); chk("t1_data", rd_a[0], 32'h5);
        set_addr(2'd3); chk("t1_cap", rd_a[0], 32'h5);
        chk("t1_irq", 32'(irq_v[0]), 32'd0);

        // Mask and write-1-to-clear
        bus_write(2'd2, 32'h4); chk("t2_irq_on", 32'(irq_v[0]), 32'd1);
        bus_write(2'd3, 32'h4); chk("t2_irq_off", 32'(irq_v[0]), 32'd0);
        set_addr(2'd3); chk("t2_cap1", rd_a[0], 32'h1);
        bus_write(2'd3, 32'h1);
        set_addr(2'd3); chk("t2_cap0", rd_a[0], 32'h0);
        bus_write(2'd2, 32'h0);

        // Debounce: short pulse rejected, long hold accepted after 6 edges
        address = 2'd0;
        in_v[1] = 32'h1; tick(3); in_v[1] = 32'h0; tick(8);
        chk("t3_glitch_data", rd_a[1], 32'h0);
        set_addr(2'd3); chk("t3_glitch_cap", rd_a[1], 32'h0);
        address = 2'd0;
        in_v[1] = 32'h1;
        tick(6); chk("t3_lat_before", rd_a[1], 32'h0);
        tick(1); chk("t3_lat_at", rd_a[1], 32'h1);
        set_addr(2'd3); chk("t3_cap", rd_a[1], 32'h1);

        // Capture set coinciding with a clear of the same bit
        in_v[0] = 32'h7;
        tick(3);
        bus_write(2'd3, 32'h2);
        set_addr(2'd3); chk("t4_collide", rd_a[0], 32'h2);
        bus_write(2'd3, 32'h2);
        set_addr(2'd3); chk("t4_clear", rd_a[0], 32'h0);

        // Falling-only vs any-edge, and bit 31 access
        bus_write(2'd3, 32'hFFFF_FFFF);
        in_v[2] = 32'h8000_0000; in_v[3] = 32'h01; tick(10);
        set_addr(2'd3);
        chk("t5_rise_et1", rd_a[2], 32'h0);
        chk("t5_rise_et2", rd_a[3], 32'h1);
        bus_write(2'd3, 32'hFFFF_FFFF);
        in_v[2] = 32'h0; in_v[3] = 32'h0; tick(10);
        set_addr(2'd3);
        chk("t5_fall_et1", rd_a[2], 32'h8000_0000);
        chk("t5_fall_et2", rd_a[3], 32'h1);
        bus_write(2'd2, 32'h8000_0001);
        set_addr(2'd2);
        chk("t5_mask32", rd_a[2], 32'h8000_0001);
        chk("t5_mask4", rd_a[0], 32'h1);
        chk("t5_irq31", 32'(irq_v[2]), 32'd1);
        bus_write(2'd3, 32'h8000_0000);
        chk("t5_irq31_off", 32'(irq_v[2]), 32'd0);

        // Reset in the middle of a debounce with everything pending
        bus_write(2'd2, 32'hF);
        in_v[0] = 32'h0; tick(6);
        bus_write(2'd3, 32'hFFFF_FFFF);
        in_v[0] = 32'hF; tick(6);
        set_addr(2'd3); chk("t6_cap", rd_a[0], 32'hF);
        chk("t6_irq", 32'(irq_v[0]), 32'd1);
        in_v[1] = 32'h0; tick(3);
        reset_n = 1'b0;
        #1;
        chk("t6_rst_rd0", rd_a[0], 32'h0);
        chk("t6_rst_irq0", 32'(irq_v[0]), 32'd0);
        chk("t6_rst_rd1", rd_a[1], 32'h0);
        for (int k = 0; k < NI; k++) in_v[k] = 32'd0;
        tick(2);
        reset_n = 1'b1;
        tick(10);
        set_addr(2'd3);
        chk("t6_post_cap0", rd_a[0], 32'h0);
        chk("t6_post_cap1", rd_a[1], 32'h0);

        // Random traffic and input toggling
        for (int c = 0; c < 3000; c++) begin
            address    = 2'($urandom_range(0, 3));
            chipselect = 1'($urandom_range(0, 1));
            write_n    = ($urandom_range(0, 3) != 0);
            writedata  = $urandom;
            for (int k = 0; k < NI; k++) begin
                in_v[k] = (in_v[k] ^ ($urandom & $urandom & $urandom)) & wmask(PW[k]);
            end
            tick(1);
        end
        chipselect = 1'b0; write_n = 1'b1;
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
